mdu_iter: RTL and testbench

Parametrised multiply/divide unit for the execute stage of the pipelined CPU. It holds the HI/LO register pair, runs a multi-cycle multiply and a bit-serial restoring divide, and supports multiply-accumulate. It reports `busy` to the hazard controller, which stalls dependent HI/LO instructions. An in-flight operation can be cancelled by `abort`, which the CPU drives from the interrupt request so that a flushed instruction leaves HI/LO untouched.

---
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_iter.sv | 206 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side issues requests and reads HI/LO.
  modport master (
    output start, op, a, b, abort,
    input  busy, done, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, a, b, abort,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding the HI/LO pair. Multiplies complete after a fixed
// latency (optionally accumulating into HI/LO); divides run one restoring step per cycle
// followed by a sign-fixup cycle. Abort cancels any in-flight op without touching HI/LO.
module mdu_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  localparam int unsigned CntW = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES);
  localparam logic [CntW-1:0] DivLoad = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
  typedef enum logic [1:0] {AccNone, AccAdd, AccSub} acc_e;

  state_e                 state_q, state_d;
  acc_e                   acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  // quo_q starts as the dividend magnitude; quotient bits shift in as dividend bits shift out.
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic                   qneg_q, qneg_d;
  logic                   rneg_q, rneg_d;
  logic                   div0_q, div0_d;

  logic                   sgn_op;
  logic [2*WIDTH-1:0]     ext_a, ext_b, prod_full;
  logic [2*WIDTH-1:0]     hilo, mul_res;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         rem_shift;
  logic                   rem_ge;
  logic [WIDTH-1:0]       rem_sub, rem_step;
  logic [WIDTH-1:0]       quo_fix, rem_fix;

  // Operand conditioning and per-cycle datapath results.
  always_comb begin
    sgn_op    = (bus.op == OpMult) || (bus.op == OpDiv) || (bus.op == OpMadd) ||
                (bus.op == OpMsub);
    ext_a     = sgn_op ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    ext_b     = sgn_op ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    // Truncated 2W x 2W product of extended operands is exact for both signednesses.
    prod_full = ext_a * ext_b;
    a_mag     = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    hilo = {hi_q, lo_q};
    unique case (acc_q)
      AccAdd:  mul_res = hilo + prod_q;
      AccSub:  mul_res = hilo - prod_q;
      default: mul_res = prod_q;
    endcase

    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, dvs_q};
    // When rem_ge holds the difference is below the divisor, so W bits suffice.
    rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
    rem_step  = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];

    quo_fix = qneg_q ? -quo_q : quo_q;
    rem_fix = rneg_q ? -rem_q : rem_q;
  end

  // Next-state: op dispatch, iteration and result writeback, with abort overriding all.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            OpMthi: hi_d = bus.a;
            OpMtlo: lo_d = bus.a;
            OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu: begin
              prod_d  = prod_full;
              acc_d   = ((bus.op == OpMadd) || (bus.op == OpMaddu)) ? AccAdd :
                        ((bus.op == OpMsub) || (bus.op == OpMsubu)) ? AccSub : AccNone;
              cnt_d   = MulLoad;
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              quo_d   = a_mag;
              dvs_d   = b_mag;
              rem_d   = '0;
              qneg_d  = sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              rneg_d  = sgn_op && bus.a[WIDTH-1];
              div0_d  = (bus.b == '0);
              cnt_d   = DivLoad;
              state_d = StDiv;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = StIdle;
        end
      end
      StDiv: begin
        rem_d = rem_step;
        quo_d = {quo_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // Divide-by-zero leaves |a| in the remainder, so the sign fixup restores a in HI.
        lo_d    = div0_q ? '1 : quo_fix;
        hi_d    = rem_fix;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort drops the op (or a same-cycle start) and blocks any writeback this cycle.
    if (bus.abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= AccNone;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: a 32-bit/5-cycle instance and an 8-bit/1-cycle instance.
module tb_mdu_iter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  logic dn;

  mdu_iter_if #(.WIDTH(32)) f32 ();
  mdu_iter_if #(.WIDTH(8))  f8 ();

  mdu_iter #(.WIDTH(32), .MUL_CYCLES(5)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (f32)
  );

  mdu_iter #(.WIDTH(8), .MUL_CYCLES(1)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (f8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle32(output int n);
    n = 0;
    while (f32.busy && n < 100) begin
      n++;
      step();
    end
  endtask

  // Issue one op, count busy cycles, and return done as seen in the first non-busy cycle.
  task automatic do_op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic d);
    f32.start = 1'b1;
    f32.op    = op;
    f32.a     = a;
    f32.b     = b;
    step();
    f32.start = 1'b0;
    f32.op    = 4'd0;
    wait_idle32(n);
    d = f32.done;
  endtask

  task automatic do_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int n, output logic d);
    f8.start = 1'b1;
    f8.op    = op;
    f8.a     = a;
    f8.b     = b;
    step();
    f8.start = 1'b0;
    f8.op    = 4'd0;
    n = 0;
    while (f8.busy && n < 100) begin
      n++;
      step();
    end
    d = f8.done;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    f32.start = 1'b0;
    f32.op    = 4'd0;
    f32.a     = '0;
    f32.b     = '0;
    f32.abort = 1'b0;
    f8.start  = 1'b0;
    f8.op     = 4'd0;
    f8.a      = '0;
    f8.b      = '0;
    f8.abort  = 1'b0;
    step();
    step();
    check("rst_hi", 64'(f32.hi), 64'h0);
    check("rst_lo", 64'(f32.lo), 64'h0);
    check("rst_busy", 64'(f32.busy), 64'h0);
    check("rst_done", 64'(f32.done), 64'h0);
    reset = 1'b1;
    step();

    // mult / multu
    do_op32(4'd1, 32'hFFFF_FFFE, 32'd3, cyc, dn);
    check("mult_busy", 64'(cyc), 64'd5);
    check("mult_done", 64'(dn), 64'd1);
    check("mult_hi", 64'(f32.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(f32.lo), 64'hFFFF_FFFA);
    step();
    check("mult_done_once", 64'(f32.done), 64'd0);
    do_op32(4'd2, 32'hFFFF_FFFE, 32'd3, cyc, dn);
    check("multu_hi", 64'(f32.hi), 64'h2);
    check("multu_lo", 64'(f32.lo), 64'hFFFF_FFFA);

    // div / divu
    do_op32(4'd3, 32'hFFFF_FFF9, 32'd2, cyc, dn);
    check("div_busy", 64'(cyc), 64'd33);
    check("div_done", 64'(dn), 64'd1);
    check("div_lo", 64'(f32.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(f32.hi), 64'hFFFF_FFFF);
    do_op32(4'd3, 32'd7, 32'hFFFF_FFFE, cyc, dn);
    check("div_nb_lo", 64'(f32.lo), 64'hFFFF_FFFD);
    check("div_nb_hi", 64'(f32.hi), 64'h1);
    do_op32(4'd4, 32'd7, 32'd0, cyc, dn);
    check("divu0_hi", 64'(f32.hi), 64'h7);
    check("divu0_lo", 64'(f32.lo), 64'hFFFF_FFFF);
    do_op32(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dn);
    check("divmin_lo", 64'(f32.lo), 64'h8000_0000);
    check("divmin_hi", 64'(f32.hi), 64'h0);

    // mthi/mtlo and accumulate
    do_op32(4'd5, 32'd0, 32'd0, cyc, dn);
    do_op32(4'd6, 32'hFFFF_FFFF, 32'd0, cyc, dn);
    check("mtlo_busy", 64'(cyc), 64'd0);
    check("mtlo_done", 64'(dn), 64'd0);
    check("mtlo_lo", 64'(f32.lo), 64'hFFFF_FFFF);
    check("mthi_hi", 64'(f32.hi), 64'h0);
    do_op32(4'd8, 32'd1, 32'd1, cyc, dn);
    check("maddu_hi", 64'(f32.hi), 64'h1);
    check("maddu_lo", 64'(f32.lo), 64'h0);
    do_op32(4'd10, 32'd1, 32'd1, cyc, dn);
    check("msubu_hi", 64'(f32.hi), 64'h0);
    check("msubu_lo", 64'(f32.lo), 64'hFFFF_FFFF);
    do_op32(4'd8, 32'd1, 32'd1, cyc, dn);
    check("b2b_first_lo", 64'(f32.lo), 64'h0);
    do_op32(4'd7, 32'd2, 32'd3, cyc, dn);
    check("b2b_madd_busy", 64'(cyc), 64'd5);
    check("b2b_madd_hi", 64'(f32.hi), 64'h1);
    check("b2b_madd_lo", 64'(f32.lo), 64'h6);

    // abort mid-divide, then start+abort in idle
    do_op32(4'd5, 32'h11, 32'd0, cyc, dn);
    do_op32(4'd6, 32'h22, 32'd0, cyc, dn);
    f32.start = 1'b1;
    f32.op    = 4'd3;
    f32.a     = 32'd100;
    f32.b     = 32'd3;
    step();
    f32.start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("abort_pre_busy", 64'(f32.busy), 64'd1);
    f32.abort = 1'b1;
    step();
    f32.abort = 1'b0;
    check("abort_busy", 64'(f32.busy), 64'd0);
    check("abort_done", 64'(f32.done), 64'd0);
    check("abort_hi", 64'(f32.hi), 64'h11);
    check("abort_lo", 64'(f32.lo), 64'h22);
    step();
    check("abort_late_done", 64'(f32.done), 64'd0);
    f32.start = 1'b1;
    f32.op    = 4'd5;
    f32.a     = 32'h55;
    f32.abort = 1'b1;
    step();
    check("sa_mthi_hi", 64'(f32.hi), 64'h11);
    f32.op = 4'd3;
    step();
    f32.start = 1'b0;
    f32.abort = 1'b0;
    check("sa_div_busy", 64'(f32.busy), 64'd0);

    // reset during MUL cycle 3
    f32.start = 1'b1;
    f32.op    = 4'd1;
    f32.a     = 32'd2;
    f32.b     = 32'd3;
    step();
    f32.start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mrst_hi", 64'(f32.hi), 64'h0);
    check("mrst_lo", 64'(f32.lo), 64'h0);
    check("mrst_busy", 64'(f32.busy), 64'd0);
    check("mrst_done", 64'(f32.done), 64'd0);

    // mthi while busy is ignored
    do_op32(4'd5, 32'h33, 32'd0, cyc, dn);
    f32.start = 1'b1;
    f32.op    = 4'd1;
    f32.a     = 32'd2;
    f32.b     = 32'd3;
    step();
    f32.op = 4'd5;
    f32.a  = 32'h99;
    step();
    f32.start = 1'b0;
    f32.op    = 4'd0;
    check("busy_mthi_hi", 64'(f32.hi), 64'h33);
    wait_idle32(cyc);
    check("busy_mthi_res_hi", 64'(f32.hi), 64'h0);
    check("busy_mthi_res_lo", 64'(f32.lo), 64'h6);
    check("busy_mthi_done", 64'(f32.done), 64'd1);

    // 8-bit, single-cycle multiply instance
    do_op8(4'd1, 8'h80, 8'h80, cyc, dn);
    check("w8_mult_busy", 64'(cyc), 64'd1);
    check("w8_mult_done", 64'(dn), 64'd1);
    check("w8_mult_hi", 64'(f8.hi), 64'h40);
    check("w8_mult_lo", 64'(f8.lo), 64'h00);
    do_op8(4'd4, 8'd200, 8'd7, cyc, dn);
    check("w8_divu_busy", 64'(cyc), 64'd9);
    check("w8_divu_lo", 64'(f8.lo), 64'd28);
    check("w8_divu_hi", 64'(f8.hi), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
